// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the multiplexed 7-segment display scanner:
//   NDIG       number of digits scanned
//   IDX_W      width of the digit index
//   AN_BLANK   anode pattern with every digit dark (active-low)
//   SEG_BLANK  segment pattern with every segment off (active-low)
//   GLYPH_TBL  hex glyphs, bit order {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam int NDIG  = 8;
    localparam int IDX_W = 3;

    localparam logic [NDIG-1:0] AN_BLANK  = 8'hFF;
    localparam logic [6:0]      SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/seg7_dec.sv
// ----------------------------------------------------------------------------
// seg7_dec
// Combinational hex-nibble to 7-segment glyph decoder.
// Ports:
//   i_nib  4-bit hex value
//   o_seg  glyph {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module seg7_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = GLYPH_TBL[i_nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// A prescaler divides clk into digit slots; each slot starts with BLANK dark
// cycles to suppress ghosting. New display data is loaded into a shadow
// register and committed only at a frame boundary so a frame never mixes
// old and new digits.
// Parameters:
//   PRESCALE  clk cycles per digit slot (2 .. 2^20)
//   BLANK     dark cycles at the start of every slot (0 .. PRESCALE-1)
// Ports:
//   clk      clock, rising edge
//   rstn     asynchronous active-low reset
//   load     one-cycle strobe capturing data into the shadow register
//   data     eight hex nibbles, nibble k drives digit k
//   mask     digit enable, bit k = 0 keeps digit k dark
//   an       digit anodes, active-low, at most one low
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   upd_ack  one-cycle pulse after the shadow value reaches the display
// ----------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [31:0]     data,
    input  logic [NDIG-1:0] mask,
    output logic [NDIG-1:0] an,
    output logic [6:0]      seg,
    output logic            upd_ack
);

    localparam int              PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    r_presc;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_shadow;
    logic [31:0]      r_active;
    logic             r_pending;
    logic             r_upd_ack;
    logic [NDIG-1:0]  r_an;
    logic [6:0]       r_seg;

    logic             w_tick;
    logic             w_frame;
    logic             w_commit;
    logic             w_dark;
    logic [NDIG-1:0]  w_an_nxt;
    logic [3:0]       w_nib;
    logic [6:0]       w_glyph;
    logic [6:0]       w_seg_nxt;

    assign w_tick   = (r_presc == PMAX);
    assign w_frame  = w_tick && (r_idx == IDX_W'(NDIG - 1));
    assign w_commit = w_frame && r_pending;

    // The signed compare keeps BLANK = 0 well-defined (never dark).
    assign w_dark   = (int'(r_presc) < BLANK) || !mask[r_idx];
    assign w_an_nxt = w_dark ? AN_BLANK : ~(NDIG'(1) << r_idx);

    assign w_nib    = r_active[{r_idx, 2'b00} +: 4];

    seg7_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_glyph)
    );

    assign w_seg_nxt = w_dark ? SEG_BLANK : w_glyph;

    // Scan timing: prescaler and digit index
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Double-buffered data: commit reads the shadow value from before this
    // edge, while a coincident load refills the shadow and keeps pending set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_upd_ack <= 1'b0;
        end else begin
            r_upd_ack <= w_commit;
            if (w_commit) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (load) begin
                r_shadow  <= data;
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_an  <= AN_BLANK;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign upd_ack = r_upd_ack;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with PRESCALE=4. Two instances share all
// inputs: dut uses BLANK=1, dut_b0 uses BLANK=0. Edge k counts rising edges
// since reset release; edge k shows slot ((k-1)/4)%8, phase (k-1)%4, and
// edges that are multiples of 32 are frame boundaries.
// ----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  mask = 8'hFF;

    logic [7:0]  an,  an0;
    logic [6:0]  seg, seg0;
    logic        ack, ack0;

    seg_scan_ctrl #(.PRESCALE(4), .BLANK(1)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .data    (data),
        .mask    (mask),
        .an      (an),
        .seg     (seg),
        .upd_ack (ack)
    );

    seg_scan_ctrl #(.PRESCALE(4), .BLANK(0)) dut_b0 (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .data    (data),
        .mask    (mask),
        .an      (an0),
        .seg     (seg0),
        .upd_ack (ack0)
    );

    always #5 clk = ~clk;

    int          errors   = 0;
    int          checks   = 0;
    int          k        = 0;
    int          ack_seen = 0;
    logic [31:0] sh_m     = '0;
    logic [31:0] act_m    = '0;
    logic        pend_m   = 1'b0;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] an_exp(input int kk, input logic [7:0] m, input int blank);
        int s;
        int p;
        s = ((kk - 1) / 4) % 8;
        p = (kk - 1) % 4;
        if (p < blank || !m[s]) return 8'hFF;
        return ~(8'h01 << s);
    endfunction

    function automatic logic [6:0] seg_exp(input logic [7:0] a, input int kk, input logic [31:0] act);
        int s;
        s = ((kk - 1) / 4) % 8;
        if (a == 8'hFF) return 7'h7F;
        return glyph(act[s*4 +: 4]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, k);
        end
    endtask

    // One rising edge; expectations come from state before the edge.
    task automatic step();
        int          kn;
        logic [7:0]  a1, a0;
        logic [6:0]  s1, s0;
        logic        ackm;
        kn   = k + 1;
        a1   = an_exp(kn, mask, 1);
        a0   = an_exp(kn, mask, 0);
        s1   = seg_exp(a1, kn, act_m);
        s0   = seg_exp(a0, kn, act_m);
        ackm = ((kn % 32) == 0) && pend_m;
        if (ackm) begin
            act_m  = sh_m;
            pend_m = 1'b0;
        end
        if (load) begin
            sh_m   = data;
            pend_m = 1'b1;
        end
        @(posedge clk);
        k = kn;
        @(negedge clk);
        chk("an",       32'(an),   32'(a1));
        chk("seg",      32'(seg),  32'(s1));
        chk("upd_ack",  32'(ack),  32'(ackm));
        chk("an_b0",    32'(an0),  32'(a0));
        chk("seg_b0",   32'(seg0), 32'(s0));
        chk("ack_b0",   32'(ack0), 32'(ackm));
        if (ack === 1'b1) ack_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [31:0] d);
        data = d;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_an",    32'(an),   32'hFF);
        chk("rst_seg",   32'(seg),  32'h7F);
        chk("rst_ack",   32'(ack),  32'h0);
        chk("rst_an_b0", 32'(an0),  32'hFF);
        chk("rst_seg_b0",32'(seg0), 32'h7F);
        chk("rst_ack_b0",32'(ack0), 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        k      = 0;
        sh_m   = '0;
        act_m  = '0;
        pend_m = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        do_reset();

        // Scan after reset, all digits enabled, active value zero
        step();
        chk("first_blank", 32'(an), 32'hFF);
        step();
        chk("d0_an", 32'(an), 32'hFE);
        chk("d0_seg", 32'(seg), 32'h40);
        run(4);
        chk("d1_an", 32'(an), 32'hFD);
        run(34);

        // Mid-frame load only shows after the wrap
        do_load(32'h7654_3210);
        run(22);
        chk("pre_commit_seg", 32'(seg), 32'h40);
        step();
        chk("commit_ack", 32'(ack), 32'h1);
        step();
        chk("ack_one_cycle", 32'(ack), 32'h0);
        run(5);
        chk("dig1_an", 32'(an), 32'hFD);
        chk("dig1_seg", 32'(seg), 32'h79);
        run(24);
        chk("dig7_an", 32'(an), 32'h7F);
        chk("dig7_seg", 32'(seg), 32'h78);
        run(2);

        // Two loads in one frame: last one wins, single commit
        ack_seen = 0;
        run(3);
        do_load(32'h1111_1111);
        run(9);
        do_load(32'hFFFF_FFFF);
        run(20);
        chk("single_ack", 32'(ack_seen), 32'd1);
        chk("allF_seg", 32'(seg), 32'h0E);

        // Load on the commit edge defers to the next boundary
        run(9);
        do_load(32'h8888_8888);
        ack_seen = 0;
        run(19);
        data = 32'hAAAA_AAAA;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("ack_88", 32'(ack), 32'h1);
        run(2);
        chk("seg_88", 32'(seg), 32'h00);
        run(30);
        chk("ack_AA", 32'(ack), 32'h1);
        chk("two_acks", 32'(ack_seen), 32'd2);
        run(2);
        chk("seg_AA", 32'(seg), 32'h08);

        // Masked upper digits; BLANK=0 instance has no dark phase
        mask = 8'h0F;
        run(20);
        chk("mask_an", 32'(an), 32'hFF);
        chk("mask_seg", 32'(seg), 32'h7F);
        chk("mask_an_b0", 32'(an0), 32'hFF);
        run(11);
        chk("noblank_an_b0", 32'(an0), 32'hFE);
        chk("blank_an", 32'(an), 32'hFF);
        mask = 8'hFF;

        // Reset in slot 5 with data pending discards it
        run(5);
        do_load(32'h1234_5678);
        run(15);
        do_reset();
        ack_seen = 0;
        run(2);
        chk("post_rst_an", 32'(an), 32'hFE);
        chk("post_rst_seg", 32'(seg), 32'h40);
        run(38);
        chk("post_rst_no_ack", 32'(ack_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 100000, clk cycles per digit slot (legal 2..2^20).
REQ-002 Parameter BLANK, default 2, cycles per slot with all anodes off (ghosting guard); legal 0..PRESCALE-1.
REQ-003 Port clk, input, 1, single clock; all flops on its rising edge.
REQ-004 Port rstn, input, 1, reset is asynchronous and active-low.
REQ-005 Port load, input, 1, one-cycle strobe capturing data into the shadow register.
REQ-006 Port data, input, 32, eight hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-007 Port mask, input, 8, digit enable; bit k = 0 keeps digit k dark.
REQ-008 Port an, output, 8, digit anodes, active-low, at most one bit low.
REQ-009 Port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port upd_ack, output, 1, one-cycle pulse when the shadow value is committed to the display.

Function
REQ-011 Prescaler presc SHALL count 0..PRESCALE-1 and wrap; tick = (presc == PRESCALE-1).
REQ-012 The 3-bit digit index idx SHALL increment on every tick, wrapping 7 -> 0, and hold otherwise.
REQ-013 Frame boundary = tick with idx == 7.
REQ-014 On load, shadow <= data and pending <= 1; a later load before commit SHALL overwrite shadow (last load wins).
REQ-015 At a frame boundary with pending == 1: active <= shadow (the value held before that edge), pending <= 0, upd_ack high for exactly the next cycle.
REQ-016 A load coinciding with a commit edge SHALL be captured into shadow, leave pending == 1, and commit at the following frame boundary.
REQ-017 A frame boundary with pending == 0 SHALL leave active unchanged, with no upd_ack.
REQ-018 an and seg SHALL be registered, one cycle of latency after idx/presc/mask/active.
REQ-019 Next an: all 1 if presc < BLANK or mask[idx] == 0; else 0 only at bit idx.
REQ-020 Next seg: 7'h7F whenever next an is all 1; else the active-low hex glyph of active nibble idx.
REQ-021 Glyphs: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
REQ-022 mask SHALL be sampled every cycle with no frame synchronisation; a change takes effect on the next registered update.

Reset
REQ-023 On rstn low, asynchronously: presc=0, idx=0, shadow=0, active=0, pending=0, upd_ack=0, an=8'hFF, seg=7'h7F.
REQ-024 A reset mid-frame or with pending set SHALL discard pending data; after release, scanning restarts at digit 0, presc 0.
REQ-025 First tick SHALL occur PRESCALE cycles after the first clock edge with rstn high.

Structure
REQ-026 The shared package seg_pkg SHALL hold NDIG=8, the glyph table and the blank constants 8'hFF/7'h7F.
REQ-027 A single combinational sub-module seg7_dec (4-bit nibble -> 7-bit active-low glyph) SHALL be instantiated once.

Verification (PRESCALE=4, BLANK=1 unless stated)
REQ-028 Reset release, mask=FF, no load -> idx steps 0..7 every 4 cycles; each slot shows an all 1 for 1 cycle, then 8'hFE,FD,... for 3 cycles; seg=40.
REQ-029 load data=0x76543210 mid-frame -> display unchanged until wrap 7->0; upd_ack pulses once; digit 1 shows seg=79, digit 7 shows 78.
REQ-030 Two loads (0x11111111, then 0xFFFFFFFF) within one frame -> single commit, single upd_ack, all digits seg=0E.
REQ-031 Load 0xAAAAAAAA on the commit edge while 0x88888888 pending -> 88888888 committed now, AAAAAAAA at the next boundary, two upd_ack pulses one frame apart.
REQ-032 mask=0x0F -> an bits 7:4 never low, seg=7F during slots 4..7; BLANK=0 -> no dark cycle in enabled slots.
REQ-033 rstn pulsed low at idx=5 with pending=1 -> outputs FF/7F immediately; after release no upd_ack, digit 0 shows 40.
